// File: rtl/hacd_irq_ctrl.sv
// Watermark interrupt controller: NUM_CH debounced count-vs-watermark channels behind a register port.
// Optional macro HACD_IRQ_PULSE_EN turns irq_o from a level into a one-cycle rising-edge pulse.
module hacd_irq_ctrl #(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 32,
  parameter int HOLD_CYCLES = 4,
  parameter int ADDR_W      = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NUM_CH*CNT_W-1:0] cnt_i,
  input  logic                    reg_valid_i,
  input  logic                    reg_write_i,
  input  logic [ADDR_W-1:0]       reg_addr_i,
  input  logic [31:0]             reg_wdata_i,
  output logic                    reg_ready_o,
  output logic [31:0]             reg_rdata_o,
  output logic                    reg_err_o,
  output logic [NUM_CH-1:0]       irq_o
);

  localparam int              DBW  = $clog2(HOLD_CYCLES + 1);
  localparam logic [DBW-1:0]  HOLD = DBW'(HOLD_CYCLES);

  logic [NUM_CH-1:0] en_q, en_d, pend_q, pend_d, dir_q, dir_d;
  logic [NUM_CH-1:0] armed_q, armed_d, irq_q, irq_d;
  logic [CNT_W-1:0]  wm_q [NUM_CH];
  logic [CNT_W-1:0]  wm_d [NUM_CH];
  logic [DBW-1:0]    db_q [NUM_CH];
  logic [DBW-1:0]    db_d [NUM_CH];
  logic              ready_q, ready_d, err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
`ifdef HACD_IRQ_PULSE_EN
  logic [NUM_CH-1:0] lvl_q, lvl_d;
`endif

  // Address decode
  logic [ADDR_W-1:0] wm_off;
  logic [ADDR_W-3:0] wm_idx;
  logic sel_en, sel_pend, sel_sw, sel_dir, sel_wm, hit;
  logic unused_bits;

  always_comb begin
    wm_off   = reg_addr_i - ADDR_W'(16);
    wm_idx   = wm_off[ADDR_W-1:2];
    sel_en   = (reg_addr_i == ADDR_W'(0));
    sel_pend = (reg_addr_i == ADDR_W'(4));
    sel_sw   = (reg_addr_i == ADDR_W'(8));
    sel_dir  = (reg_addr_i == ADDR_W'(12));
    sel_wm   = (reg_addr_i[1:0] == 2'b00) && (reg_addr_i >= ADDR_W'(16)) &&
               ({2'b00, wm_idx} < ADDR_W'(NUM_CH));
    hit      = sel_en | sel_pend | sel_sw | sel_dir | sel_wm;
  end

  assign unused_bits = ^wm_off[1:0];

  logic [NUM_CH-1:0] w1c, sw_set, hw_set;
  logic              cond;
  logic              wr, rd;

  // NOTE: every signal gets a default at the top of the block so no path can leave it unassigned (no latch).
  always_comb begin
    en_d    = en_q;
    dir_d   = dir_q;
    armed_d = armed_q;
    wm_d    = wm_q;
    db_d    = db_q;
    w1c     = '0;
    sw_set  = '0;
    hw_set  = '0;
    cond    = 1'b0;
    rdata_d = '0;
    wr      = reg_valid_i & reg_write_i;
    rd      = reg_valid_i & ~reg_write_i;
    ready_d = reg_valid_i;
    err_d   = reg_valid_i & ~hit;

    if (wr) begin
      if (sel_en)   en_d   = reg_wdata_i[NUM_CH-1:0];
      if (sel_dir)  dir_d  = reg_wdata_i[NUM_CH-1:0];
      if (sel_pend) w1c    = reg_wdata_i[NUM_CH-1:0];
      if (sel_sw)   sw_set = reg_wdata_i[NUM_CH-1:0];
    end
    if (rd) begin
      if (sel_en)   rdata_d = 32'(en_q);
      if (sel_pend) rdata_d = 32'(pend_q);
      if (sel_dir)  rdata_d = 32'(dir_q);
    end

    for (int c = 0; c < NUM_CH; c++) begin
      if (sel_wm && ({2'b00, wm_idx} == ADDR_W'(c))) begin
        if (wr) wm_d[c] = reg_wdata_i[CNT_W-1:0];
        if (rd) rdata_d = 32'(wm_q[c]);
      end

      // Compare uses registered WM/DIR, so a reprogram applies from the next cycle.
      cond = dir_q[c] ? (cnt_i[c*CNT_W +: CNT_W] < wm_q[c])
                      : (cnt_i[c*CNT_W +: CNT_W] > wm_q[c]);
      if (!cond) begin
        db_d[c]    = '0;
        armed_d[c] = 1'b1;
      end else if (armed_q[c]) begin
        if (db_q[c] + 1'b1 == HOLD) begin
          hw_set[c]  = 1'b1;
          armed_d[c] = 1'b0;
          db_d[c]    = '0;
        end else begin
          db_d[c] = db_q[c] + 1'b1;
        end
      end
    end

    // Set sources win over a same-cycle write-1-to-clear.
    pend_d = (pend_q & ~w1c) | sw_set | hw_set;

`ifdef HACD_IRQ_PULSE_EN
    lvl_d = pend_q & en_q;
    irq_d = lvl_d & ~lvl_q;
`else
    irq_d = pend_d & en_d;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      en_q    <= '0;
      pend_q  <= '0;
      dir_q   <= '1;
      armed_q <= '1;
      irq_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
`ifdef HACD_IRQ_PULSE_EN
      lvl_q   <= '0;
`endif
      // NOTE: the watermark array is software-visible with a defined reset value, so it is reset like any register.
      for (int c = 0; c < NUM_CH; c++) begin
        wm_q[c] <= '0;
        db_q[c] <= '0;
      end
    end else begin
      en_q    <= en_d;
      pend_q  <= pend_d;
      dir_q   <= dir_d;
      armed_q <= armed_d;
      irq_q   <= irq_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
`ifdef HACD_IRQ_PULSE_EN
      lvl_q   <= lvl_d;
`endif
      wm_q    <= wm_d;
      db_q    <= db_d;
    end
  end

  assign reg_ready_o = ready_q;
  assign reg_rdata_o = rdata_q;
  assign reg_err_o   = err_q;
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_hacd_irq_ctrl.sv
// Directed self-checking bench for hacd_irq_ctrl (NUM_CH=2, CNT_W=32, HOLD_CYCLES=4).
module tb_hacd_irq_ctrl;

`ifdef HACD_IRQ_PULSE_EN
  localparam bit PULSE = 1'b1;
`else
  localparam bit PULSE = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [63:0] cnt_i = '0;
  logic        reg_valid_i = 1'b0;
  logic        reg_write_i = 1'b0;
  logic [7:0]  reg_addr_i = '0;
  logic [31:0] reg_wdata_i = '0;
  logic        reg_ready_o;
  logic [31:0] reg_rdata_o;
  logic        reg_err_o;
  logic [1:0]  irq_o;

  int checks = 0;
  int failures = 0;

  hacd_irq_ctrl #(.NUM_CH(2), .CNT_W(32), .HOLD_CYCLES(4), .ADDR_W(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .cnt_i(cnt_i),
    .reg_valid_i(reg_valid_i), .reg_write_i(reg_write_i),
    .reg_addr_i(reg_addr_i), .reg_wdata_i(reg_wdata_i),
    .reg_ready_o(reg_ready_o), .reg_rdata_o(reg_rdata_o),
    .reg_err_o(reg_err_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  // Called at a negedge: drives one access, returns at the next negedge with the response.
  task automatic do_access(input bit wr, input logic [7:0] addr, input logic [31:0] wd,
                           output logic [31:0] rd, output logic err, output logic rdy);
    reg_valid_i = 1'b1; reg_write_i = wr; reg_addr_i = addr; reg_wdata_i = wd;
    @(negedge clk_i);
    rd = reg_rdata_o; err = reg_err_o; rdy = reg_ready_o;
    reg_valid_i = 1'b0; reg_write_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic er, rdy;
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    checks++; if (irq_o !== 2'b00) begin failures++; $display("FAIL rst_irq: got %0h expected 0", irq_o); end
    checks++; if (reg_ready_o !== 1'b0 || reg_err_o !== 1'b0 || reg_rdata_o !== 32'h0) begin
      failures++; $display("FAIL rst_resp: ready=%0b err=%0b rdata=%0h expected 0/0/0", reg_ready_o, reg_err_o, reg_rdata_o); end
    do_access(0, 8'h00, 0, rd, er, rdy);
    checks++; if (rd !== 32'h0 || er !== 1'b0 || rdy !== 1'b1) begin
      failures++; $display("FAIL rst_en: got %0h err=%0b ready=%0b expected 0 err=0 ready=1", rd, er, rdy); end
    do_access(0, 8'h04, 0, rd, er, rdy);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rst_pend: got %0h expected 0", rd); end
    do_access(0, 8'h0C, 0, rd, er, rdy);
    checks++; if (rd !== 32'h3) begin failures++; $display("FAIL rst_dir: got %0h expected 3", rd); end
    do_access(0, 8'h10, 0, rd, er, rdy);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rst_wm0: got %0h expected 0", rd); end
  endtask

  task automatic test_debounce();
    logic [31:0] rd; logic er, rdy;
    cnt_i[31:0] = 32'd150;
    do_access(1, 8'h10, 32'd100, rd, er, rdy);
    do_access(1, 8'h00, 32'h1, rd, er, rdy);
    cnt_i[31:0] = 32'd99;
    repeat (3) @(negedge clk_i);
    cnt_i[31:0] = 32'd150;
    checks++; if (irq_o[0] !== 1'b0) begin failures++; $display("FAIL db_short3: got %0b expected 0", irq_o[0]); end
    @(negedge clk_i);
    checks++; if (irq_o[0] !== 1'b0) begin failures++; $display("FAIL db_break: got %0b expected 0", irq_o[0]); end
    cnt_i[31:0] = 32'd99;
    repeat (3) @(negedge clk_i);
    checks++; if (irq_o[0] !== 1'b0) begin failures++; $display("FAIL db_cyc3: got %0b expected 0", irq_o[0]); end
    @(negedge clk_i);
    checks++; if (irq_o[0] !== !PULSE) begin failures++; $display("FAIL db_cyc4: got %0b expected %0b", irq_o[0], !PULSE); end
    @(negedge clk_i);
    checks++; if (irq_o[0] !== 1'b1) begin failures++; $display("FAIL db_cyc5: got %0b expected 1", irq_o[0]); end
    @(negedge clk_i);
    checks++; if (irq_o[0] !== !PULSE) begin failures++; $display("FAIL db_cyc6: got %0b expected %0b", irq_o[0], !PULSE); end
    do_access(0, 8'h04, 0, rd, er, rdy);
    checks++; if (rd !== 32'h1) begin failures++; $display("FAIL db_pend: got %0h expected 1", rd); end
  endtask

  task automatic test_rearm();
    logic [31:0] rd; logic er, rdy;
    do_access(1, 8'h04, 32'h1, rd, er, rdy);
    checks++; if (irq_o[0] !== 1'b0) begin failures++; $display("FAIL w1c_irq: got %0b expected 0", irq_o[0]); end
    repeat (5) @(negedge clk_i);
    checks++; if (irq_o[0] !== 1'b0) begin failures++; $display("FAIL held_irq: got %0b expected 0", irq_o[0]); end
    do_access(0, 8'h04, 0, rd, er, rdy);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL no_reraise: got %0h expected 0", rd); end
    cnt_i[31:0] = 32'd100;
    @(negedge clk_i);
    cnt_i[31:0] = 32'd99;
    repeat (3) @(negedge clk_i);
    checks++; if (irq_o[0] !== 1'b0) begin failures++; $display("FAIL rearm_cyc3: got %0b expected 0", irq_o[0]); end
    @(negedge clk_i);
    checks++; if (irq_o[0] !== !PULSE) begin failures++; $display("FAIL rearm_cyc4: got %0b expected %0b", irq_o[0], !PULSE); end
    @(negedge clk_i);
    checks++; if (irq_o[0] !== 1'b1) begin failures++; $display("FAIL rearm_cyc5: got %0b expected 1", irq_o[0]); end
    do_access(1, 8'h04, 32'h1, rd, er, rdy);
    cnt_i[31:0] = 32'd150;
  endtask

  task automatic test_collision();
    logic [31:0] rd; logic er, rdy;
    do_access(1, 8'h14, 32'd100, rd, er, rdy);
    cnt_i[63:32] = 32'd99;
    repeat (3) @(negedge clk_i);
    do_access(1, 8'h04, 32'h2, rd, er, rdy);   // W1C lands on the same edge as the hardware set
    do_access(0, 8'h04, 0, rd, er, rdy);
    checks++; if (rd !== 32'h2) begin failures++; $display("FAIL collision: got %0h expected 2", rd); end
    do_access(1, 8'h04, 32'h2, rd, er, rdy);
    do_access(0, 8'h04, 0, rd, er, rdy);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL w1c_bit1: got %0h expected 0", rd); end
    cnt_i[63:32] = 32'd200;
  endtask

  task automatic test_swtrig();
    logic [31:0] rd; logic er, rdy;
    do_access(1, 8'h00, 32'h0, rd, er, rdy);
    do_access(1, 8'h08, 32'h2, rd, er, rdy);
    checks++; if (irq_o !== 2'b00) begin failures++; $display("FAIL sw_masked: got %0h expected 0", irq_o); end
    do_access(0, 8'h04, 0, rd, er, rdy);
    checks++; if (rd !== 32'h2) begin failures++; $display("FAIL sw_pend: got %0h expected 2", rd); end
    do_access(0, 8'h08, 0, rd, er, rdy);
    checks++; if (rd !== 32'h0 || er !== 1'b0) begin failures++; $display("FAIL sw_read: got %0h err=%0b expected 0 err=0", rd, er); end
    do_access(1, 8'h00, 32'h2, rd, er, rdy);
    checks++; if (irq_o !== (PULSE ? 2'b00 : 2'b10)) begin failures++; $display("FAIL en_irq0: got %0h expected %0h", irq_o, PULSE ? 2'b00 : 2'b10); end
    @(negedge clk_i);
    checks++; if (irq_o !== 2'b10) begin failures++; $display("FAIL en_irq1: got %0h expected 2", irq_o); end
    @(negedge clk_i);
    checks++; if (irq_o !== (PULSE ? 2'b00 : 2'b10)) begin failures++; $display("FAIL en_irq2: got %0h expected %0h", irq_o, PULSE ? 2'b00 : 2'b10); end
    do_access(1, 8'h04, 32'h3, rd, er, rdy);
    do_access(1, 8'h00, 32'h0, rd, er, rdy);
  endtask

  task automatic test_addr_err();
    logic [31:0] rd; logic er, rdy;
    do_access(0, 8'h40, 0, rd, er, rdy);
    checks++; if (rd !== 32'h0 || er !== 1'b1 || rdy !== 1'b1) begin
      failures++; $display("FAIL err_rd40: got %0h err=%0b ready=%0b expected 0 err=1 ready=1", rd, er, rdy); end
    do_access(1, 8'h18, 32'hFFFF, rd, er, rdy);
    checks++; if (er !== 1'b1) begin failures++; $display("FAIL err_wr18: err=%0b expected 1", er); end
    do_access(1, 8'h40, 32'hFF, rd, er, rdy);
    do_access(0, 8'h00, 0, rd, er, rdy);
    checks++; if (rd !== 32'h0 || er !== 1'b0) begin failures++; $display("FAIL err_en_kept: got %0h err=%0b expected 0 err=0", rd, er); end
    do_access(0, 8'h14, 0, rd, er, rdy);
    checks++; if (rd !== 32'd100) begin failures++; $display("FAIL err_wm1_kept: got %0h expected 64", rd); end
    do_access(1, 8'h0C, 32'hFFFF_FFFC, rd, er, rdy);
    do_access(0, 8'h0C, 0, rd, er, rdy);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL dir_hibits: got %0h expected 0", rd); end
    do_access(1, 8'h0C, 32'h3, rd, er, rdy);
  endtask

  task automatic test_back_to_back();
    reg_valid_i = 1'b1; reg_write_i = 1'b1; reg_addr_i = 8'h14; reg_wdata_i = 32'h55;
    @(negedge clk_i);
    checks++; if (reg_ready_o !== 1'b1 || reg_err_o !== 1'b0) begin
      failures++; $display("FAIL b2b_wr: ready=%0b err=%0b expected 1/0", reg_ready_o, reg_err_o); end
    reg_write_i = 1'b0;
    @(negedge clk_i);
    reg_valid_i = 1'b0;
    checks++; if (reg_ready_o !== 1'b1 || reg_rdata_o !== 32'h55) begin
      failures++; $display("FAIL b2b_rd: ready=%0b rdata=%0h expected 1/55", reg_ready_o, reg_rdata_o); end
    @(negedge clk_i);
    checks++; if (reg_ready_o !== 1'b0) begin failures++; $display("FAIL b2b_idle: ready=%0b expected 0", reg_ready_o); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er, rdy;
    do_access(1, 8'h10, 32'd100, rd, er, rdy);
    do_access(1, 8'h00, 32'h1, rd, er, rdy);
    cnt_i[31:0] = 32'd99;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (4) @(negedge clk_i);
    checks++; if (irq_o !== 2'b00) begin failures++; $display("FAIL rmid_irq: got %0h expected 0", irq_o); end
    do_access(0, 8'h04, 0, rd, er, rdy);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rmid_pend: got %0h expected 0", rd); end
    do_access(0, 8'h10, 0, rd, er, rdy);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rmid_wm0: got %0h expected 0", rd); end
    do_access(0, 8'h00, 0, rd, er, rdy);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rmid_en: got %0h expected 0", rd); end
  endtask

  initial begin
    @(negedge clk_i);
    test_reset();
    test_debounce();
    test_rearm();
    test_collision();
    test_swtrig();
    test_addr_err();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hacd_irq_ctrl.md
Name: hacd_irq_ctrl

Overview:
- Parametrised interrupt controller for the hacd subsystem; replaces fixed ctrl-bit-driven inflate/deflate interrupts.
- Provides NUM_CH channels; each compares a monitored hardware count (e.g. free-page count) against a programmable watermark.
- Each channel debounces the compare result, latches a pending bit and drives a maskable interrupt.
- Software programs and services it through a simple register port; sits beside hacd_regs inside the hacd top.

Parameters:
NUM_CH, 2, number of interrupt channels (1..16)
CNT_W, 32, width of each monitored count and watermark
HOLD_CYCLES, 4, consecutive cycles a condition must hold before pending sets (>=1)
ADDR_W, 8, register byte-address width

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
cnt_i  in  NUM_CH*CNT_W  monitored counts; channel c at [c*CNT_W +: CNT_W]
reg_valid_i  in  1  register access strobe; every high cycle is one access
reg_write_i  in  1  1 = write, 0 = read
reg_addr_i  in  ADDR_W  byte address, word aligned
reg_wdata_i  in  32  write data
reg_ready_o  out  1  response strobe, one cycle after the access
reg_rdata_o  out  32  read data, valid with reg_ready_o
reg_err_o  out  1  undefined address, valid with reg_ready_o
irq_o  out  NUM_CH  per-channel interrupt

Behaviour:
- Register map (byte addresses):
  - 0x00 EN: RW [NUM_CH-1:0].
  - 0x04 PEND: read = pending; write-1-to-clear.
  - 0x08 SWTRIG: write-1-to-set pending; reads 0.
  - 0x0C DIR: RW. Bit 1 = trigger when cnt < wm; bit 0 = trigger when cnt > wm.
  - 0x10+4*c WM[c]: RW, low CNT_W bits.
- Undefined-address or out-of-range channel access: read data 0, reg_err_o=1, no state change. Bits above NUM_CH and CNT_W read 0.
- Register access latency:
  - reg_ready_o, reg_rdata_o and reg_err_o are registered, one cycle after reg_valid_i.
  - Back-to-back accesses are allowed.
  - A write takes effect on the edge it is sampled.
- Reset values: EN=0, PEND=0, DIR=all 1, WM=0, debounce counters=0, armed=1. reg_ready_o=0, reg_rdata_o=0, reg_err_o=0, irq_o=0.
- Per-channel state: debounce counter of width $clog2(HOLD_CYCLES+1), plus armed flag.
  - cond = DIR ? (cnt < wm) : (cnt > wm), unsigned, computed from current inputs and registers.
  - When cond=0: counter clears and armed is set to 1.
  - When cond=1 and armed: counter increments, saturating at HOLD_CYCLES.
  - When the counter reaches HOLD_CYCLES: pending sets, armed clears, counter clears.
  - Timing: if cond is 1 on cycles t..t+HOLD_CYCLES-1, pending is visible at t+HOLD_CYCLES.
  - A condition that stays true does not re-raise pending after a clear. cond must go false for at least one cycle to re-arm.
- Pending sets regardless of EN. irq_o = PEND & EN, driven from flops only (no combinational path from inputs).
- Simultaneous events:
  - Hardware set or SWTRIG in the same cycle as a W1C of the same bit: set wins.
  - Writing WM or DIR mid-debounce does not clear the counter; the new compare applies from the next cycle.
- Reset mid-debounce or with pending set returns every channel to reset values on the next edge.

Optional Feature:
- Macro: HACD_IRQ_PULSE_EN.
- Defined: irq_o[c] is a one-cycle pulse on the cycle after PEND[c]&EN[c] rises from 0 to 1. PEND still holds level state for polling.
- Not defined: irq_o is the level PEND & EN, as above.

Test Plan:
- Reset defaults: after reset, read 0x00/0x04/0x0C/0x10 -> 0, 0, {NUM_CH{1}}, 0; irq_o=0.
- Debounce threshold: WM[0]=100, DIR[0]=1, EN=1; cnt0=99 for 3 cycles then 150 -> no pending. cnt0=99 for 4 cycles -> PEND[0]=1 and irq_o[0]=1 at cycle 4.
- Clear and re-arm: hold cnt0=99, write PEND=1 -> irq_o[0]=0 and stays 0. Raise cnt0 to 100 for one cycle, then 99 for 4 cycles -> pending again.
- Collision and SWTRIG: pending sets on the same edge as a W1C of bit 1 -> PEND[1]=1. SWTRIG=0x2 with EN=0 -> PEND[1]=1, irq_o[1]=0; then EN=0x2 -> irq_o[1]=1.
- Address error: read 0x40 -> rdata 0, reg_err_o=1 one cycle later, no state change. Back-to-back write WM[1]=0x55 then read WM[1] -> 0x55.
- Pulse mode (HACD_IRQ_PULSE_EN): same stimulus as the debounce-threshold test -> irq_o[0] high exactly one cycle; reset mid-debounce at cycle 2 -> no pending.
